hyp_err_acc: RTL and testbench

- Streaming error-metric accumulator placed directly downstream of the 128-bit hypotenuse datapath.
- Each sample pairs the approximate circuit output with the exact reference output.
- Accumulates error count, maximum absolute error and saturating sum of absolute error over a programmed number of samples.
- Replaces per-sample text dumps with on-chip statistics for approximate-logic evaluation runs.

---
 rtl/hyp_pkg.sv | 13 +
 rtl/hyp_err_acc_if.sv | 13 +
 rtl/hyp_absdiff.sv | 15 +
 rtl/hyp_err_acc.sv | 132 +++++++++++++
 tb/tb_hyp_err_acc.sv | 393 +++++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/hyp_pkg.sv
// Shared constants and FSM state type for the hypotenuse error-metric blocks.
// No logic; latency and backpressure are not applicable.
package hyp_pkg;
  localparam int HYP_WIDTH = 128;
  localparam int HYP_CNT_W = 20;
  localparam int HYP_ACC_W = 160;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } hyp_state_e;
endpackage

// File: rtl/hyp_err_acc_if.sv
// Approx/exact sample stream: a transfer happens on in_valid && in_ready.
// No latency; the only backpressure is in_ready from the slave.
interface hyp_err_acc_if #(
  parameter int WIDTH = hyp_pkg::HYP_WIDTH
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] approx;
  logic [WIDTH-1:0] exact;

  modport master (output in_valid, output approx, output exact, input in_ready);
  modport slave  (input in_valid, input approx, input exact, output in_ready);
endinterface

// File: rtl/hyp_absdiff.sv
// Unsigned |a-b| without wrap plus an inequality flag.
// Purely combinational (zero latency); no backpressure.
module hyp_absdiff #(
  parameter int WIDTH = hyp_pkg::HYP_WIDTH
) (
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  output logic [WIDTH-1:0] o_diff,
  output logic             o_ne
);
  always_comb begin
    o_diff = (i_a >= i_b) ? (i_a - i_b) : (i_b - i_a);
    o_ne   = (i_a != i_b);
  end
endmodule

// File: rtl/hyp_err_acc.sv
// Accumulates error count, max |err| and saturating sum |err| over a programmed run.
// Latency 2 cycles transfer-to-stats, done one cycle later; backpressure via registered in_ready only.
module hyp_err_acc
  import hyp_pkg::*;
#(
  parameter int WIDTH = HYP_WIDTH,
  parameter int ACC_W = HYP_ACC_W,
  parameter int CNT_W = HYP_CNT_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [CNT_W-1:0] num_samples,
  hyp_err_acc_if.slave     s_if,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] err_count,
  output logic [WIDTH-1:0] max_err,
  output logic [ACC_W-1:0] sum_err,
  output logic             sat
);

  hyp_state_e       r_state;
  hyp_state_e       w_state_nxt;
  logic [CNT_W-1:0] r_num;
  logic [CNT_W-1:0] r_accepted;
  logic [CNT_W-1:0] r_processed;
  logic             r_in_ready;
  logic             r_s1_vld;
  logic             r_s1_ne;
  logic [WIDTH-1:0] r_s1_diff;
  logic [CNT_W-1:0] r_err_count;
  logic [WIDTH-1:0] r_max_err;
  logic [ACC_W-1:0] r_sum_err;
  logic             r_sat;

  logic [WIDTH-1:0] w_diff;
  logic             w_ne;
  logic             w_xfer;
  logic             w_start_ok;
  logic [CNT_W-1:0] w_num_nxt;
  logic [CNT_W-1:0] w_acc_nxt;
  logic [ACC_W:0]   w_sum;

  hyp_absdiff #(.WIDTH(WIDTH)) u_absdiff (
    .i_a    (s_if.approx),
    .i_b    (s_if.exact),
    .o_diff (w_diff),
    .o_ne   (w_ne)
  );

  assign w_xfer     = s_if.in_valid && r_in_ready;
  assign w_start_ok = start && (r_state != ST_RUN);
  assign w_num_nxt  = w_start_ok ? num_samples : r_num;
  assign w_acc_nxt  = w_start_ok ? '0 : (r_accepted + CNT_W'(w_xfer));
  // One spare bit catches the carry out that signals saturation.
  assign w_sum      = {1'b0, r_sum_err} + {{(ACC_W + 1 - WIDTH){1'b0}}, r_s1_diff};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE, ST_DONE: begin
        if (start) w_state_nxt = (num_samples == '0) ? ST_DONE : ST_RUN;
      end
      ST_RUN: begin
        // processed only reaches num once every sample has left stage 2
        if (r_processed == r_num) w_state_nxt = ST_DONE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_num      <= '0;
      r_accepted <= '0;
      r_in_ready <= 1'b0;
      r_s1_vld   <= 1'b0;
      r_s1_ne    <= 1'b0;
      r_s1_diff  <= '0;
    end else begin
      r_num      <= w_num_nxt;
      r_accepted <= w_acc_nxt;
      r_in_ready <= (w_state_nxt == ST_RUN) && (w_acc_nxt < w_num_nxt);
      r_s1_vld   <= w_xfer;
      if (w_xfer) begin
        r_s1_diff <= w_diff;
        r_s1_ne   <= w_ne;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_processed <= '0;
      r_err_count <= '0;
      r_max_err   <= '0;
      r_sum_err   <= '0;
      r_sat       <= 1'b0;
    end else if (w_start_ok) begin
      r_processed <= '0;
      r_err_count <= '0;
      r_max_err   <= '0;
      r_sum_err   <= '0;
      r_sat       <= 1'b0;
    end else if (r_s1_vld) begin
      r_processed <= r_processed + 1'b1;
      r_err_count <= r_err_count + CNT_W'(r_s1_ne);
      if (r_s1_diff > r_max_err) r_max_err <= r_s1_diff;
      if (w_sum[ACC_W]) begin
        r_sum_err <= '1;
        r_sat     <= 1'b1;
      end else begin
        r_sum_err <= w_sum[ACC_W-1:0];
      end
    end
  end

  assign s_if.in_ready = r_in_ready;
  assign busy          = (r_state == ST_RUN);
  assign done          = (r_state == ST_DONE);
  assign err_count     = r_err_count;
  assign max_err       = r_max_err;
  assign sum_err       = r_sum_err;
  assign sat           = r_sat;

endmodule

// File: tb/tb_hyp_err_acc.sv
// Randomised bench for hyp_err_acc against a true-arithmetic reference model.
// A second instance with a 130-bit accumulator covers saturation.
module tb_hyp_err_acc;
  import hyp_pkg::*;

  localparam int W      = HYP_WIDTH;
  localparam int CW     = HYP_CNT_W;
  localparam int AW     = HYP_ACC_W;
  localparam int AW_SAT = 130;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          sel = 1'b0;
  logic          drv_valid = 1'b0;
  logic          drv_start = 1'b0;
  logic [W-1:0]  drv_a = '0;
  logic [W-1:0]  drv_b = '0;
  logic [CW-1:0] drv_num = '0;

  hyp_err_acc_if #(.WIDTH(W)) m_if ();
  hyp_err_acc_if #(.WIDTH(W)) s_if ();

  assign m_if.in_valid = drv_valid & ~sel;
  assign s_if.in_valid = drv_valid & sel;
  assign m_if.approx   = drv_a;
  assign m_if.exact    = drv_b;
  assign s_if.approx   = drv_a;
  assign s_if.exact    = drv_b;

  logic              m_start, s_start;
  logic              m_busy, m_done, m_sat, s_busy, s_done, s_sat;
  logic [CW-1:0]     m_err, s_err;
  logic [W-1:0]      m_max, s_max;
  logic [AW-1:0]     m_sum;
  logic [AW_SAT-1:0] s_sum;

  assign m_start = drv_start & ~sel;
  assign s_start = drv_start & sel;

  hyp_err_acc #(.WIDTH(W), .ACC_W(AW), .CNT_W(CW)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(m_start), .num_samples(drv_num), .s_if(m_if),
    .busy(m_busy), .done(m_done), .err_count(m_err), .max_err(m_max), .sum_err(m_sum), .sat(m_sat)
  );

  hyp_err_acc #(.WIDTH(W), .ACC_W(AW_SAT), .CNT_W(CW)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(s_start), .num_samples(drv_num), .s_if(s_if),
    .busy(s_busy), .done(s_done), .err_count(s_err), .max_err(s_max), .sum_err(s_sum), .sat(s_sat)
  );

  logic          o_ready, o_busy, o_done, o_sat;
  logic [CW-1:0] o_err;
  logic [W-1:0]  o_max;
  logic [AW-1:0] o_sum;
  assign o_ready = sel ? s_if.in_ready : m_if.in_ready;
  assign o_busy  = sel ? s_busy : m_busy;
  assign o_done  = sel ? s_done : m_done;
  assign o_sat   = sel ? s_sat  : m_sat;
  assign o_err   = sel ? s_err  : m_err;
  assign o_max   = sel ? s_max  : m_max;
  assign o_sum   = sel ? {{(AW-AW_SAT){1'b0}}, s_sum} : m_sum;

  int vec  = 0;
  int errs = 0;

  // Reference model: exact integer sum, clamped only when compared.
  logic [259:0] m_sum_t;
  logic [W-1:0] m_max_t;
  int           m_cnt_t;

  task automatic model_clear();
    m_sum_t = '0;
    m_max_t = '0;
    m_cnt_t = 0;
  endtask

  task automatic model_add(input logic [W-1:0] a, input logic [W-1:0] b);
    logic signed [W+1:0] x;
    x = $signed({2'b00, a}) - $signed({2'b00, b});
    if (x < 0) x = -x;
    if (x != 0) m_cnt_t++;
    if (x[W-1:0] > m_max_t) m_max_t = x[W-1:0];
    m_sum_t = m_sum_t + 260'(x);
  endtask

  function automatic logic [259:0] sum_limit();
    logic [259:0] one;
    one = 260'd1;
    return (one << (sel ? AW_SAT : AW)) - one;
  endfunction

  function automatic logic [AW-1:0] exp_sum();
    logic [259:0] lim;
    lim = sum_limit();
    return (m_sum_t > lim) ? lim[AW-1:0] : m_sum_t[AW-1:0];
  endfunction

  function automatic logic exp_sat();
    return m_sum_t > sum_limit();
  endfunction

  function automatic logic [W-1:0] rnd_w();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start(input int n);
    drv_num   = CW'(n);
    drv_start = 1'b1;
    tick();
    drv_start = 1'b0;
    model_clear();
  endtask

  task automatic send(input logic [W-1:0] a, input logic [W-1:0] b);
    bit hs;
    hs        = 1'b0;
    drv_a     = a;
    drv_b     = b;
    drv_valid = 1'b1;
    for (int k = 0; k < 200 && !hs; k++) begin
      hs = o_ready;
      tick();
    end
    drv_valid = 1'b0;
    vec++;
    if (!hs) begin
      errs++;
      $display("FAIL send_timeout in_ready=%b required a transfer within 200 cycles", o_ready);
    end else begin
      model_add(a, b);
    end
  endtask

  task automatic wait_done(input int budget, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < budget && !ok; k++) begin
      if (o_done) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    bit ok;
    rst_n = 1'b0;
    repeat (3) tick();
    vec++;
    if ({o_busy, o_done, o_ready, o_sat} !== 4'b0000) begin
      errs++; $display("FAIL reset_flags got=%b want=0000", {o_busy, o_done, o_ready, o_sat});
    end
    vec++;
    if (o_err !== '0 || o_max !== '0 || o_sum !== '0) begin
      errs++; $display("FAIL reset_stats err=%0d max=%0h sum=%0h want zeros", o_err, o_max, o_sum);
    end
    rst_n = 1'b1;
    tick();
    do_start(10);
    vec++;
    if (o_busy !== 1'b1) begin errs++; $display("FAIL run_busy got=%b want=1", o_busy); end
    for (int i = 0; i < 4; i++) begin
      logic [W-1:0] a;
      a = rnd_w();
      send(a, a ^ W'(1));
    end
    #2 rst_n = 1'b0;
    #1;
    vec++;
    if ({o_busy, o_done, o_ready, o_sat} !== 4'b0000 || o_err !== '0 || o_max !== '0 || o_sum !== '0) begin
      errs++;
      $display("FAIL midrun_reset flags=%b err=%0d max=%0h sum=%0h want all zero",
               {o_busy, o_done, o_ready, o_sat}, o_err, o_max, o_sum);
    end
    tick();
    rst_n = 1'b1;
    tick();
    do_start(2);
    send(W'(5), W'(5));
    send(W'(9), W'(4));
    wait_done(20, ok);
    vec++;
    if (!ok || o_err !== CW'(1) || o_max !== W'(5) || o_sum !== AW'(5)) begin
      errs++;
      $display("FAIL post_reset_run done=%b err=%0d max=%0d sum=%0d want 1/1/5/5", o_done, o_err, o_max, o_sum);
    end
  endtask

  task automatic test_back_to_back();
    int n;
    n = 0;
    do_start(1000);
    drv_valid = 1'b1;
    for (int k = 0; k < 1200 && n < 1000; k++) begin
      bit hs;
      drv_a = W'(n);
      drv_b = W'(n);
      hs = o_ready;
      tick();
      if (hs) n++;
    end
    vec++;
    if (n !== 1000 || o_ready !== 1'b0) begin
      errs++; $display("FAIL stream_xfers got=%0d ready=%b want 1000 ready=0", n, o_ready);
    end
    tick();
    vec++;
    if (o_done !== 1'b0 || o_ready !== 1'b0) begin
      errs++; $display("FAIL stream_done_early done=%b ready=%b want 0/0", o_done, o_ready);
    end
    tick();
    drv_valid = 1'b0;
    vec++;
    if (o_done !== 1'b1) begin errs++; $display("FAIL stream_done_latency done=%b want 1", o_done); end
    vec++;
    if (o_err !== '0 || o_max !== '0 || o_sum !== '0 || o_sat !== 1'b0) begin
      errs++; $display("FAIL stream_stats err=%0d max=%0h sum=%0h sat=%b want zeros", o_err, o_max, o_sum, o_sat);
    end
  endtask

  task automatic test_sign_symmetry();
    bit ok;
    logic [AW-1:0] e_sum;
    e_sum = AW'(140) + {{(AW-W){1'b0}}, {W{1'b1}}};
    do_start(3);
    send(W'(100), W'(30));
    send(W'(30), W'(100));
    send(W'(0), {W{1'b1}});
    wait_done(20, ok);
    vec++;
    if (!ok || o_err !== CW'(3) || o_max !== {W{1'b1}}) begin
      errs++; $display("FAIL sym_cnt_max done=%b err=%0d max=%0h want 1/3/all-ones", o_done, o_err, o_max);
    end
    vec++;
    if (o_sum !== e_sum || o_sat !== 1'b0) begin
      errs++; $display("FAIL sym_sum got=%0h sat=%b want %0h sat=0", o_sum, o_sat, e_sum);
    end
  endtask

  task automatic test_zero_restart();
    bit ok;
    bit rdy_seen;
    do_start(0);
    vec++;
    if (o_done !== 1'b1 || o_busy !== 1'b0) begin
      errs++; $display("FAIL zero_done done=%b busy=%b want 1/0", o_done, o_busy);
    end
    vec++;
    if (o_err !== '0 || o_max !== '0 || o_sum !== '0) begin
      errs++; $display("FAIL zero_cleared err=%0d max=%0h sum=%0h want zeros", o_err, o_max, o_sum);
    end
    rdy_seen  = 1'b0;
    drv_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      if (o_ready) rdy_seen = 1'b1;
      tick();
    end
    drv_valid = 1'b0;
    vec++;
    if (rdy_seen !== 1'b0) begin errs++; $display("FAIL zero_ready got=1 want 0"); end
    do_start(1);
    vec++;
    if (o_done !== 1'b0 || o_busy !== 1'b1) begin
      errs++; $display("FAIL restart_state done=%b busy=%b want 0/1", o_done, o_busy);
    end
    send(W'(7), W'(3));
    wait_done(20, ok);
    vec++;
    if (!ok || o_err !== CW'(1) || o_sum !== AW'(4) || o_max !== W'(4)) begin
      errs++; $display("FAIL restart_stats done=%b err=%0d sum=%0d max=%0d want 1/1/4/4", o_done, o_err, o_sum, o_max);
    end
  endtask

  task automatic test_gap_start();
    bit ok;
    int extra;
    int drops;
    do_start(3);
    for (int i = 0; i < 3; i++) begin
      repeat ($urandom_range(0, 3)) tick();
      if (i == 1) begin
        drv_num   = CW'(7);
        drv_start = 1'b1;
        tick();
        drv_start = 1'b0;
        vec++;
        if (o_busy !== 1'b1 || o_done !== 1'b0) begin
          errs++; $display("FAIL ignored_start busy=%b done=%b want 1/0", o_busy, o_done);
        end
      end
      send(rnd_w(), rnd_w());
    end
    extra     = 0;
    drv_valid = 1'b1;
    for (int k = 0; k < 6; k++) begin
      if (o_ready) extra++;
      tick();
    end
    drv_valid = 1'b0;
    wait_done(20, ok);
    vec++;
    if (!ok || extra !== 0) begin
      errs++; $display("FAIL gap_xfers done=%b extra=%0d want 1/0", o_done, extra);
    end
    vec++;
    if (o_err !== CW'(m_cnt_t) || o_max !== m_max_t || o_sum !== exp_sum() || o_sat !== exp_sat()) begin
      errs++; $display("FAIL gap_stats err=%0d max=%0h sum=%0h want %0d %0h %0h", o_err, o_max, o_sum, m_cnt_t, m_max_t, exp_sum());
    end
    drops = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (o_done !== 1'b1) drops++;
    end
    vec++;
    if (drops !== 0) begin errs++; $display("FAIL gap_done_hold drops=%0d want 0", drops); end
  endtask

  task automatic test_random();
    for (int r = 0; r < 4; r++) begin
      bit ok;
      int n;
      n = $urandom_range(1, 16);
      do_start(n);
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] a, b;
        a = rnd_w();
        case ($urandom_range(0, 3))
          0:       b = a;
          1:       b = a + W'($urandom_range(0, 5));
          2:       b = a - W'($urandom_range(0, 1000));
          default: b = rnd_w();
        endcase
        repeat ($urandom_range(0, 2)) tick();
        send(a, b);
      end
      wait_done(20, ok);
      vec++;
      if (!ok || o_err !== CW'(m_cnt_t) || o_max !== m_max_t) begin
        errs++; $display("FAIL rand_cnt_max run=%0d done=%b err=%0d max=%0h want %0d %0h", r, o_done, o_err, o_max, m_cnt_t, m_max_t);
      end
      vec++;
      if (o_sum !== exp_sum() || o_sat !== exp_sat()) begin
        errs++; $display("FAIL rand_sum run=%0d got=%0h sat=%b want %0h sat=%b", r, o_sum, o_sat, exp_sum(), exp_sat());
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    sel = 1'b1;
    do_start(5);
    for (int i = 0; i < 4; i++) send({W{1'b1}}, W'(0));
    repeat (3) tick();
    vec++;
    if (o_sat !== 1'b0 || o_sum !== exp_sum()) begin
      errs++; $display("FAIL presat got sum=%0h sat=%b want %0h sat=0", o_sum, o_sat, exp_sum());
    end
    send({W{1'b1}}, W'(0));
    wait_done(20, ok);
    vec++;
    if (!ok || o_sat !== 1'b1 || o_sum !== exp_sum() || !exp_sat()) begin
      errs++; $display("FAIL sat_sum done=%b sum=%0h sat=%b want %0h sat=1", o_done, o_sum, o_sat, exp_sum());
    end
    vec++;
    if (o_max !== {W{1'b1}} || o_err !== CW'(5)) begin
      errs++; $display("FAIL sat_cnt_max max=%0h err=%0d want all-ones/5", o_max, o_err);
    end
    sel = 1'b0;
  endtask

  initial begin
    model_clear();
    test_reset();
    test_back_to_back();
    test_sign_symmetry();
    test_zero_restart();
    test_gap_start();
    test_random();
    test_saturation();
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
